// File: rtl/siaminer_pkg.sv
// Shared framing constants, state types and command decode for the siaminer command router.
package siaminer_pkg;

    localparam logic [7:0] HDR_RX        = 8'hAA;
    localparam logic [7:0] HDR_TX        = 8'h55;
    localparam logic [7:0] CMD_WORK      = 8'h00;
    localparam logic [7:0] CMD_LOOP      = 8'h01;
    localparam logic [7:0] CMD_WORK_CORE = 8'h10;
    localparam logic [7:0] RSP_NONCE     = 8'h00;
    localparam logic [7:0] NONCE_RSP_LEN = 8'd5;
    localparam int         CORE_W        = 4;

    typedef enum logic [2:0] {RX_IDLE, RX_CMD, RX_LEN, RX_DATA, RX_DONE} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_HDR, TX_CMD, TX_LEN, TX_DATA} tx_state_t;
    typedef enum logic [1:0] {K_WORK_ALL, K_WORK_CORE, K_LOOP, K_BAD} frame_kind_t;

    function automatic frame_kind_t decode_cmd(input logic [7:0] cmd, input int ncores);
        if (cmd == CMD_WORK) return K_WORK_ALL;
        if (cmd == CMD_LOOP) return K_LOOP;
        if (cmd[7:4] == CMD_WORK_CORE[7:4] && int'(cmd[3:0]) < ncores) return K_WORK_CORE;
        return K_BAD;
    endfunction

    function automatic int wrap_idx(input int a, input int n);
        return (a >= n) ? a - n : a;
    endfunction

endpackage

// File: rtl/siaminer_tx_framer.sv
// Response framer: picks loop echo or a pending nonce slot and serialises it as a 0x55 frame.
//  state   | meaning
//  TX_IDLE | arbitrate: loop echo first, else round-robin over pending nonce slots
//  TX_HDR  | presenting 0x55 header
//  TX_CMD  | presenting response command (0x01 loop / 0x00 nonce)
//  TX_LEN  | presenting payload length
//  TX_DATA | presenting payload bytes, back to idle after the last one
module siaminer_tx_framer
    import siaminer_pkg::*;
#(
    parameter int NCORES     = 4,
    parameter int LOOP_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_byte,
    input  logic                    loop_pending,
    input  logic [7:0]              loop_len,
    input  logic [LOOP_DEPTH*8-1:0] loop_data,
    input  logic [NCORES-1:0]       nonce_pending,
    input  logic [NCORES*32-1:0]    nonce_slots,
    output logic                    loop_take,
    output logic [NCORES-1:0]       nonce_clr,
    output logic                    loop_active
);

    tx_state_t             state;
    logic                  sel_loop;
    logic [7:0]            len_q;
    logic [7:0]            idx;
    logic [7:0]            rem;
    logic [31:0]           nonce_q;
    logic [CORE_W-1:0]     id_q;
    logic [CORE_W-1:0]     last_core;
    logic [CORE_W-1:0]     rr_pick;
    logic                  rr_hit;
    logic [NCORES-1:0]     pend_sh;
    logic [NCORES*32-1:0]  nonce_sel;
    logic [7:0]            rd_idx;
    logic [7:0]            rd_byte;
    logic [LOOP_DEPTH*8-1:0] loop_sh;
    logic [31:0]           nonce_sh;

    // Scan downwards so the core nearest after last_core is the one that sticks.
    always_comb begin
        rr_pick = '0;
        rr_hit  = 1'b0;
        pend_sh = '0;
        for (int k = NCORES; k >= 1; k--) begin
            pend_sh = nonce_pending >> wrap_idx(int'(last_core) + k, NCORES);
            if (pend_sh[0]) begin
                rr_pick = CORE_W'(wrap_idx(int'(last_core) + k, NCORES));
                rr_hit  = 1'b1;
            end
        end
    end

    assign nonce_sel   = nonce_slots >> {rr_pick, 5'b00000};
    assign loop_take   = (state == TX_IDLE) && loop_pending;
    assign nonce_clr   = (state == TX_IDLE && !loop_pending && rr_hit) ? (NCORES'(1) << rr_pick) : '0;
    assign loop_active = (state != TX_IDLE) && sel_loop;

    always_comb begin
        rd_idx   = (state == TX_DATA) ? idx + 8'd1 : 8'd0;
        loop_sh  = loop_data >> {rd_idx, 3'b000};
        nonce_sh = nonce_q >> {rd_idx, 3'b000};
        if (sel_loop)
            rd_byte = loop_sh[7:0];
        else if (rd_idx < 8'd4)
            rd_byte = nonce_sh[7:0];
        else
            rd_byte = {{(8-CORE_W){1'b0}}, id_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= TX_IDLE;
            tx_valid  <= 1'b0;
            tx_byte   <= 8'h00;
            sel_loop  <= 1'b0;
            len_q     <= 8'h00;
            idx       <= 8'h00;
            rem       <= 8'h00;
            nonce_q   <= 32'h0;
            id_q      <= '0;
            last_core <= CORE_W'(NCORES - 1);
        end else begin
            case (state)
                TX_IDLE: begin
                    if (loop_pending || rr_hit) begin
                        sel_loop <= loop_pending;
                        len_q    <= loop_pending ? loop_len : NONCE_RSP_LEN;
                        if (!loop_pending) begin
                            nonce_q   <= nonce_sel[31:0];
                            id_q      <= rr_pick;
                            last_core <= rr_pick;
                        end
                        tx_valid <= 1'b1;
                        tx_byte  <= HDR_TX;
                        state    <= TX_HDR;
                    end
                end
                TX_HDR: if (tx_ready) begin
                    tx_byte <= sel_loop ? CMD_LOOP : RSP_NONCE;
                    state   <= TX_CMD;
                end
                TX_CMD: if (tx_ready) begin
                    tx_byte <= len_q;
                    state   <= TX_LEN;
                end
                TX_LEN: if (tx_ready) begin
                    tx_byte <= rd_byte;
                    idx     <= 8'h00;
                    rem     <= len_q;
                    state   <= TX_DATA;
                end
                TX_DATA: if (tx_ready) begin
                    if (rem == 8'd1) begin
                        tx_valid <= 1'b0;
                        tx_byte  <= 8'h00;
                        state    <= TX_IDLE;
                    end else begin
                        tx_byte <= rd_byte;
                        idx     <= idx + 8'd1;
                        rem     <= rem - 8'd1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/siaminer_cmd_router.sv
// Multi-core UART command router: decodes 0xAA host frames, dispatches work, captures nonces.
// Optional RX_TIMEOUT_EN aborts a frame after TIMEOUT_CYC cycles without a received byte.
//  state   | meaning
//  RX_IDLE | hunting for 0xAA, everything else dropped
//  RX_CMD  | next byte is the command
//  RX_LEN  | next byte is the payload length; frame validity decided here
//  RX_DATA | consuming payload bytes
//  RX_DONE | one cycle: issue work_valid / queue loop echo / late error
module siaminer_cmd_router
    import siaminer_pkg::*;
#(
    parameter int NCORES      = 4,
    parameter int WORK_BYTES  = 88,
    parameter int LOOP_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_byte,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_byte,
    output logic [NCORES-1:0]       work_valid,
    output logic [WORK_BYTES*8-1:0] work_data,
    input  logic [NCORES-1:0]       core_found,
    input  logic [NCORES*32-1:0]    core_nonce,
    output logic [NCORES-1:0]       found_ack,
    output logic                    err_frame
);

    rx_state_t               rx_state;
    frame_kind_t             kind;
    logic [CORE_W-1:0]       core_sel;
    logic [7:0]              len_q;
    logic [7:0]              rem;
    logic [7:0]              wr_idx;
    logic                    discard;
    logic                    late_err;
    logic                    loop_pending;
    logic [7:0]              loop_len;
    logic [LOOP_DEPTH*8-1:0] loop_buf;
    logic [NCORES-1:0]       pending;
    logic [NCORES*32-1:0]    slots;
    logic                    loop_take;
    logic [NCORES-1:0]       nonce_clr;
    logic                    loop_active;
    logic                    loop_busy;
    logic                    to_fire;

    assign wr_idx    = len_q - rem;
    assign loop_busy = loop_pending || loop_active;

`ifdef RX_TIMEOUT_EN
    logic [31:0] to_cnt;

    assign to_fire = (rx_state != RX_IDLE) && (rx_state != RX_DONE) && !rx_valid && (to_cnt == 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= 32'(TIMEOUT_CYC - 1);
        else if (rx_valid)
            to_cnt <= 32'(TIMEOUT_CYC - 1);
        else if (rx_state != RX_IDLE && to_cnt != 32'd0)
            to_cnt <= to_cnt - 32'd1;
    end
`else
    assign to_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= RX_IDLE;
            kind         <= K_BAD;
            core_sel     <= '0;
            len_q        <= 8'h00;
            rem          <= 8'h00;
            discard      <= 1'b0;
            late_err     <= 1'b0;
            loop_pending <= 1'b0;
            loop_len     <= 8'h00;
            loop_buf     <= '0;
            work_valid   <= '0;
            work_data    <= '0;
            err_frame    <= 1'b0;
        end else begin
            work_valid <= '0;
            err_frame  <= 1'b0;
            if (loop_take)
                loop_pending <= 1'b0;
            if (to_fire) begin
                rx_state  <= RX_IDLE;
                err_frame <= 1'b1;
            end else begin
                case (rx_state)
                    RX_IDLE: if (rx_valid && rx_byte == HDR_RX) rx_state <= RX_CMD;
                    RX_CMD: if (rx_valid) begin
                        kind     <= decode_cmd(rx_byte, NCORES);
                        core_sel <= rx_byte[CORE_W-1:0];
                        rx_state <= RX_LEN;
                    end
                    RX_LEN: if (rx_valid) begin
                        len_q    <= rx_byte;
                        rem      <= rx_byte;
                        discard  <= 1'b0;
                        late_err <= 1'b0;
                        case (kind)
                            K_WORK_ALL, K_WORK_CORE: begin
                                if (int'(rx_byte) != WORK_BYTES) begin
                                    discard   <= 1'b1;
                                    err_frame <= 1'b1;
                                end
                            end
                            K_LOOP: begin
                                if (rx_byte == 8'd0 || int'(rx_byte) > LOOP_DEPTH) begin
                                    discard   <= 1'b1;
                                    err_frame <= 1'b1;
                                end else if (loop_busy) begin
                                    discard  <= 1'b1;
                                    late_err <= 1'b1;
                                end
                            end
                            default: begin
                                discard  <= 1'b1;
                                late_err <= 1'b1;
                            end
                        endcase
                        rx_state <= (rx_byte == 8'd0) ? RX_DONE : RX_DATA;
                    end
                    RX_DATA: if (rx_valid) begin
                        if (!discard && kind != K_LOOP) begin
                            for (int k = 0; k < WORK_BYTES; k++)
                                if (wr_idx == 8'(k)) work_data[8*k +: 8] <= rx_byte;
                        end
                        if (!discard && kind == K_LOOP) begin
                            for (int k = 0; k < LOOP_DEPTH; k++)
                                if (wr_idx == 8'(k)) loop_buf[8*k +: 8] <= rx_byte;
                        end
                        rem <= rem - 8'd1;
                        if (rem == 8'd1) rx_state <= RX_DONE;
                    end
                    RX_DONE: begin
                        if (!discard) begin
                            case (kind)
                                K_WORK_ALL:  work_valid <= '1;
                                K_WORK_CORE: work_valid <= NCORES'(1) << core_sel;
                                K_LOOP: begin
                                    loop_pending <= 1'b1;
                                    loop_len     <= len_q;
                                end
                                default: ;
                            endcase
                        end
                        if (late_err) err_frame <= 1'b1;
                        rx_state <= (rx_valid && rx_byte == HDR_RX) ? RX_CMD : RX_IDLE;
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // A found strobe coinciding with the framer's clear keeps the slot pending: newest nonce wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            slots     <= '0;
            found_ack <= '0;
        end else begin
            found_ack <= core_found;
            pending   <= (pending & ~nonce_clr) | core_found;
            for (int i = 0; i < NCORES; i++)
                if (core_found[i]) slots[32*i +: 32] <= core_nonce[32*i +: 32];
        end
    end

    siaminer_tx_framer #(
        .NCORES     (NCORES),
        .LOOP_DEPTH (LOOP_DEPTH)
    ) u_tx_framer (
        .clk           (clk),
        .rst           (rst),
        .tx_ready      (tx_ready),
        .tx_valid      (tx_valid),
        .tx_byte       (tx_byte),
        .loop_pending  (loop_pending),
        .loop_len      (loop_len),
        .loop_data     (loop_buf),
        .nonce_pending (pending),
        .nonce_slots   (slots),
        .loop_take     (loop_take),
        .nonce_clr     (nonce_clr),
        .loop_active   (loop_active)
    );

endmodule

// File: tb/tb_siaminer_cmd_router.sv
// Directed bench for siaminer_cmd_router with a frame-level reference model and per-cycle compare.
`timescale 1ns/1ps
module tb_siaminer_cmd_router;

    localparam int NCORES      = 4;
    localparam int WORK_BYTES  = 88;
    localparam int LOOP_DEPTH  = 8;
    localparam int TIMEOUT_CYC = 200;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    rx_valid = 1'b0;
    logic [7:0]              rx_byte = 8'h00;
    logic                    tx_ready = 1'b1;
    logic                    tx_valid;
    logic [7:0]              tx_byte;
    logic [NCORES-1:0]       work_valid;
    logic [WORK_BYTES*8-1:0] work_data;
    logic [NCORES-1:0]       core_found = '0;
    logic [NCORES*32-1:0]    core_nonce = '0;
    logic [NCORES-1:0]       found_ack;
    logic                    err_frame;

    siaminer_cmd_router #(
        .NCORES(NCORES), .WORK_BYTES(WORK_BYTES), .LOOP_DEPTH(LOOP_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_ready(tx_ready),
        .tx_valid(tx_valid), .tx_byte(tx_byte), .work_valid(work_valid), .work_data(work_data),
        .core_found(core_found), .core_nonce(core_nonce), .found_ack(found_ack), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int err_seen = 0;
    int err_exp = 0;
    int tx_count = 0;

    logic [7:0]              exp_tx[$];
    logic [NCORES-1:0]       exp_wv[$];
    logic [WORK_BYTES*8-1:0] exp_wd[$];
    logic [7:0]              payload[$];

    logic [NCORES-1:0] prev_found = '0;
    logic              prev_stall = 1'b0;
    logic [7:0]        prev_byte = 8'h00;

    // Frame-level model of the nonce slots and round-robin service order.
    logic [31:0]       m_nonce[NCORES];
    logic [NCORES-1:0] m_pend = '0;
    int                m_last = NCORES - 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_wide(input string name, input logic [WORK_BYTES*8-1:0] act,
                              input logic [WORK_BYTES*8-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_hold_valid", {63'd0, tx_valid}, 64'd1);
                check("tx_hold_byte", {56'd0, tx_byte}, {56'd0, prev_byte});
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    n_total++;
                    $display("FAIL tx_unexpected: got byte 0x%0h expected no transfer", tx_byte);
                end else begin
                    check("tx_byte", {56'd0, tx_byte}, {56'd0, exp_tx.pop_front()});
                end
                tx_count++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = tx_byte;
            check("found_ack", 64'(found_ack), 64'(prev_found));
            if (work_valid != '0) begin
                if (exp_wv.size() == 0) begin
                    n_total++;
                    $display("FAIL work_valid_unexpected: got %b expected none", work_valid);
                end else begin
                    check("work_valid", 64'(work_valid), 64'(exp_wv.pop_front()));
                    check_wide("work_data", work_data, exp_wd.pop_front());
                end
            end
            if (err_frame) err_seen++;
        end
        prev_found = core_found;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick(1);
        rx_valid = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len);
        send_byte(8'hAA);
        send_byte(cmd);
        send_byte(len);
        foreach (payload[k]) send_byte(payload[k]);
    endtask

    task automatic expect_loop(input logic [7:0] len);
        exp_tx.push_back(8'h55);
        exp_tx.push_back(8'h01);
        exp_tx.push_back(len);
        foreach (payload[k]) exp_tx.push_back(payload[k]);
    endtask

    task automatic expect_work(input logic [NCORES-1:0] mask);
        logic [WORK_BYTES*8-1:0] d;
        d = '0;
        foreach (payload[k]) d[8*k +: 8] = payload[k];
        exp_wv.push_back(mask);
        exp_wd.push_back(d);
    endtask

    task automatic model_found(input logic [NCORES-1:0] mask);
        for (int i = 0; i < NCORES; i++) begin
            if (mask[i]) begin
                m_nonce[i] = core_nonce[32*i +: 32];
                m_pend[i]  = 1'b1;
            end
        end
    endtask

    task automatic model_flush();
        int base;
        base = m_last;
        for (int k = 1; k <= NCORES; k++) begin
            int c;
            c = (base + k) % NCORES;
            if (m_pend[c]) begin
                exp_tx.push_back(8'h55);
                exp_tx.push_back(8'h00);
                exp_tx.push_back(8'h05);
                for (int b = 0; b < 4; b++) exp_tx.push_back(m_nonce[c][8*b +: 8]);
                exp_tx.push_back(8'(c));
                m_pend[c] = 1'b0;
                m_last    = c;
            end
        end
    endtask

    task automatic pulse_found(input logic [NCORES-1:0] mask);
        core_found = mask;
        tick(1);
        core_found = '0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || tx_valid) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) begin
            n_total++;
            $display("FAIL %s_timeout: %0d tx bytes still expected after %0d cycles", name, exp_tx.size(), n);
            exp_tx.delete();
        end
        tick(3);
    endtask

    task automatic wait_tx(input string name, input int target);
        int n;
        n = 0;
        while (tx_count < target && n < 500) begin
            tick(1);
            n++;
        end
        if (n >= 500) begin
            n_total++;
            $display("FAIL %s_timeout: tx_count %0d expected at least %0d", name, tx_count, target);
        end
    endtask

    task automatic end_scenario(input string name);
        tick(3);
        check({name, "_err"}, 64'(err_seen), 64'(err_exp));
        check({name, "_work_left"}, 64'(exp_wv.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < NCORES; i++) m_nonce[i] = 32'h0;
        tick(3);
        check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_tx_byte", {56'd0, tx_byte}, 64'd0);
        check("rst_work_valid", 64'(work_valid), 64'd0);
        check("rst_found_ack", 64'(found_ack), 64'd0);
        check("rst_err_frame", {63'd0, err_frame}, 64'd0);
        check_wide("rst_work_data", work_data, '0);
        rst = 1'b0;
        tick(2);

        // Loop echo with a literal expected byte stream.
        payload = '{8'h5A};
        exp_tx.push_back(8'h55); exp_tx.push_back(8'h01);
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h5A);
        send_frame(8'h01, 8'd1);
        drain("loop1", 200);
        end_scenario("loop1");

        // Noise before the header is ignored; 3-byte echo.
        send_byte(8'h12);
        send_byte(8'h55);
        payload = '{8'hA1, 8'hB2, 8'hC3};
        expect_loop(8'd3);
        send_frame(8'h01, 8'd3);
        drain("loop3", 200);
        end_scenario("loop3");

        // Work to core 2, bytes 0x00..0x57.
        payload.delete();
        for (int k = 0; k < WORK_BYTES; k++) payload.push_back(8'(k));
        expect_work(4'b0100);
        send_frame(8'h12, 8'd88);
        end_scenario("work_core2");
        check("work_byte0", {56'd0, work_data[7:0]}, 64'h00);
        check("work_byte87", {56'd0, work_data[703:696]}, 64'h57);

        // Bad work length: error, no dispatch; then a good broadcast.
        payload.delete();
        for (int k = 0; k < 87; k++) payload.push_back(8'hEE);
        err_exp++;
        send_frame(8'h00, 8'd87);
        end_scenario("work_badlen");
        check("work_data_kept", {56'd0, work_data[703:696]}, 64'h57);
        payload.delete();
        for (int k = 0; k < WORK_BYTES; k++) payload.push_back(8'(k * 7 + 3));
        expect_work(4'b1111);
        send_frame(8'h00, 8'd88);
        end_scenario("work_bcast");
        check("bcast_byte1", {56'd0, work_data[15:8]}, 64'h0A);

        // Unknown command and out-of-range core index.
        payload = '{8'h01, 8'h02};
        err_exp++;
        send_frame(8'h05, 8'd2);
        end_scenario("unknown_cmd");
        payload = '{8'h33};
        err_exp++;
        send_frame(8'h14, 8'd1);
        end_scenario("bad_core");

        // Loop length 0 and LOOP_DEPTH+1.
        payload.delete();
        err_exp++;
        send_frame(8'h01, 8'd0);
        end_scenario("loop_len0");
        payload.delete();
        for (int k = 0; k < LOOP_DEPTH + 1; k++) payload.push_back(8'(8'h40 + k));
        err_exp++;
        send_frame(8'h01, 8'(LOOP_DEPTH + 1));
        end_scenario("loop_len9");

        // Two cores find in the same cycle: served core 1 then core 3.
        core_nonce[32*1 +: 32] = 32'h11223344;
        core_nonce[32*3 +: 32] = 32'hAABBCCDD;
        model_found(4'b1010);
        model_flush();
        check("model_b0", {56'd0, exp_tx[0]}, 64'h55);
        check("model_b3", {56'd0, exp_tx[3]}, 64'h44);
        check("model_b6", {56'd0, exp_tx[6]}, 64'h11);
        check("model_b7", {56'd0, exp_tx[7]}, 64'h01);
        check("model_b15", {56'd0, exp_tx[15]}, 64'h03);
        pulse_found(4'b1010);
        drain("nonce2", 300);
        end_scenario("nonce2");

        // tx_ready stalls 50 cycles in the middle of an echo.
        payload = '{8'h11, 8'h22, 8'h33, 8'h44};
        expect_loop(8'd4);
        send_frame(8'h01, 8'd4);
        wait_tx("stall", tx_count + 2);
        tx_ready = 1'b0;
        tick(50);
        tx_ready = 1'b1;
        drain("stall", 200);
        end_scenario("stall");

        // Second loop frame while the first echo is still pending is dropped.
        tx_ready = 1'b0;
        payload = '{8'hA0, 8'hA1};
        expect_loop(8'd2);
        send_frame(8'h01, 8'd2);
        payload = '{8'hB0};
        err_exp++;
        send_frame(8'h01, 8'd1);
        tx_ready = 1'b1;
        drain("loop_busy", 200);
        end_scenario("loop_busy");

        // Re-found while pending: the latest nonce wins; RR continues after core 3.
        tx_ready = 1'b0;
        payload = '{8'hC3};
        expect_loop(8'd1);
        send_frame(8'h01, 8'd1);
        core_nonce[32*0 +: 32] = 32'h01020304;
        model_found(4'b0001);
        pulse_found(4'b0001);
        tick(2);
        core_nonce[32*0 +: 32] = 32'hCAFEF00D;
        core_nonce[32*2 +: 32] = 32'h0BADBEEF;
        model_found(4'b0101);
        pulse_found(4'b0101);
        model_flush();
        tick(2);
        tx_ready = 1'b1;
        drain("overwrite", 400);
        end_scenario("overwrite");

        // Reset in the middle of an echo.
        payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        expect_loop(8'd8);
        send_frame(8'h01, 8'd8);
        wait_tx("rst_mid", tx_count + 3);
        rst = 1'b1;
        #1;
        check("rst_mid_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_mid_tx_byte", {56'd0, tx_byte}, 64'd0);
        exp_tx.delete();
        m_pend = '0;
        m_last = NCORES - 1;
        tick(2);
        rst = 1'b0;
        tick(2);
        payload = '{8'h77};
        expect_loop(8'd1);
        send_frame(8'h01, 8'd1);
        drain("after_rst", 200);
        end_scenario("after_rst");

`ifdef RX_TIMEOUT_EN
        payload.delete();
        for (int k = 0; k < 10; k++) payload.push_back(8'(k));
        err_exp++;
        send_frame(8'h00, 8'h58);
        tick(TIMEOUT_CYC + 20);
        end_scenario("timeout");
        payload = '{8'h99};
        expect_loop(8'd1);
        send_frame(8'h01, 8'd1);
        drain("after_timeout", 200);
        end_scenario("after_timeout");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
